// File: rtl/hilo_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_md_ctrl
// Purpose  : Sequences the shared mul/div units for EX and owns HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_md_ctrl #(
    parameter int MUL_LAT     = 1,
    parameter int STALL_W     = 6,
    parameter int EX_HOLD_BIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               annul,
    input  logic [2:0]         md_op,
    input  logic [31:0]        src_a,
    input  logic [31:0]        src_b,
    output logic               mul_signed,
    output logic [31:0]        mul_ina,
    output logic [31:0]        mul_inb,
    input  logic [63:0]        mul_result,
    output logic               div_start,
    output logic               div_signed,
    output logic [31:0]        div_opa,
    output logic [31:0]        div_opb,
    output logic               div_annul,
    input  logic [63:0]        div_result,
    input  logic               div_ready,
    output logic               stallreq,
    output logic               hilo_we,
    output logic [31:0]        hi_wdata,
    output logic [31:0]        lo_wdata,
    output logic [31:0]        hi_o,
    output logic [31:0]        lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;
    localparam logic [2:0] c_MUL_CNT_INIT = (MUL_LAT > 0) ? 3'(MUL_LAT - 1) : 3'd0;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, lo_q;

    logic w_is_mul, w_is_div, w_is_mt, w_hold, w_mul_sel;

    assign w_is_mul  = (md_op == c_OP_MULT) || (md_op == c_OP_MULTU);
    assign w_is_div  = (md_op == c_OP_DIV)  || (md_op == c_OP_DIVU);
    assign w_is_mt   = (md_op == c_OP_MTHI) || (md_op == c_OP_MTLO);
    assign w_hold    = stall[EX_HOLD_BIT];
    assign w_mul_sel = !rst && w_is_mul &&
                       ((state_q == ST_IDLE) || (state_q == ST_MUL_WAIT));

    assign mul_ina    = w_mul_sel ? src_a : 32'd0;
    assign mul_inb    = w_mul_sel ? src_b : 32'd0;
    assign mul_signed = w_mul_sel && (md_op == c_OP_MULT);
    assign div_opa    = div_start ? src_a : 32'd0;
    assign div_opb    = div_start ? src_b : 32'd0;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stallreq   = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_annul  = 1'b0;
        hilo_we    = 1'b0;
        hi_wdata   = hi_q;
        lo_wdata   = lo_q;

        if (rst) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else if (annul) begin
            // Kill wins over any commit arriving in the same cycle.
            state_d   = ST_IDLE;
            cnt_d     = 3'd0;
            div_annul = (state_q == ST_DIV_WAIT);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (w_is_mt) begin
                        hilo_we = 1'b1;
                        if (md_op == c_OP_MTHI) hi_wdata = src_a;
                        else                    lo_wdata = src_a;
                        state_d = w_hold ? ST_DONE : ST_IDLE;
                    end else if (w_is_mul) begin
                        if (MUL_LAT == 0) begin
                            hilo_we  = 1'b1;
                            hi_wdata = mul_result[63:32];
                            lo_wdata = mul_result[31:0];
                            state_d  = w_hold ? ST_DONE : ST_IDLE;
                        end else begin
                            stallreq = 1'b1;
                            cnt_d    = c_MUL_CNT_INIT;
                            state_d  = ST_MUL_WAIT;
                        end
                    end else if (w_is_div && (src_b != 32'd0)) begin
                        div_start  = 1'b1;
                        div_signed = (md_op == c_OP_DIV);
                        stallreq   = 1'b1;
                        state_d    = ST_DIV_WAIT;
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt_q != 3'd0) begin
                        stallreq = 1'b1;
                        cnt_d    = cnt_q - 3'd1;
                    end else begin
                        hilo_we  = 1'b1;
                        hi_wdata = mul_result[63:32];
                        lo_wdata = mul_result[31:0];
                        state_d  = w_hold ? ST_DONE : ST_IDLE;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_ready) begin
                        hilo_we  = 1'b1;
                        hi_wdata = div_result[63:32];
                        lo_wdata = div_result[31:0];
                        state_d  = w_hold ? ST_DONE : ST_IDLE;
                    end else begin
                        div_start  = 1'b1;
                        div_signed = (md_op == c_OP_DIV);
                        stallreq   = 1'b1;
                    end
                end
                ST_DONE: begin
                    // EX still holds the committed instruction; ignore it.
                    if (!w_hold) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_wdata;
            lo_q    <= lo_wdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Sequences the shared multiply and divide units on behalf of the EX stage, and owns the HI/LO architectural registers.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time from EX and drives operands and start to the mul/div units.
- Holds the pipeline via a stall request until the result is ready, then commits the result to HI/LO and drives a same-cycle forwarding bus toward ID.

Parameters:
- MUL_LAT, 1: mul unit latency in cycles from operand presentation to valid mul_result. Legal range 0..7; 0 means combinational.
- STALL_W, 6: width of the pipeline stall bus.
- EX_HOLD_BIT, 2: index of the stall bit that freezes the ID→EX register, i.e. the EX instruction is held.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  STALL_W  pipeline stall bus; stall[EX_HOLD_BIT]=1 means the EX instruction is held next edge
- annul  in  1  kill the in-flight operation (exception/flush)
- md_op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 treated as none
- src_a  in  32  rs value
- src_b  in  32  rt value
- mul_signed  out  1  to mul unit
- mul_ina  out  32  to mul unit
- mul_inb  out  32  to mul unit
- mul_result  in  64  from mul unit
- div_start  out  1  to div unit, level, held until ready
- div_signed  out  1  to div unit
- div_opa  out  32  to div unit
- div_opb  out  32  to div unit
- div_annul  out  1  to div unit
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  div result valid
- stallreq  out  1  EX stall request to the hazard controller
- hilo_we  out  1  HI/LO written at this edge
- hi_wdata  out  32  forwarded next HI
- lo_wdata  out  32  forwarded next LO
- hi_o  out  32  registered HI
- lo_o  out  32  registered LO

Behaviour:
- Reset: state IDLE, cnt=0, hi_o=lo_o=0. All control outputs 0 (stallreq, div_start, div_annul, hilo_we). Data outputs 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- Operand outputs:
  - mul_ina/inb = src_a/src_b whenever a MULT/MULTU op is presented; else 0.
  - div_opa/opb = src_a/src_b while div_start=1; else 0.
  - EX keeps src_a/src_b stable while stallreq=1.
- IDLE, MTHI/MTLO:
  - hilo_we=1 and stallreq=0.
  - MTHI: hi_wdata=src_a, lo_wdata=lo_o.
  - MTLO: lo_wdata=src_a, hi_wdata=hi_o.
  - Stay IDLE.
- IDLE, MULT/MULTU (mul_signed=1 for MULT):
  - MUL_LAT=0: commit in the same cycle. hilo_we=1, hi_wdata=mul_result[63:32], lo_wdata=mul_result[31:0].
  - MUL_LAT>0: stallreq=1, cnt←MUL_LAT-1, go MUL_WAIT.
- MUL_WAIT:
  - While cnt≠0: stallreq=1, cnt decrements.
  - On the cycle cnt=0: stallreq=0, commit mul_result as above.
  - Total EX occupancy is MUL_LAT+1 cycles.
- IDLE, DIV/DIVU with src_b≠0:
  - div_start=1 and div_signed=(DIV); stallreq=1; go DIV_WAIT.
- IDLE, DIV/DIVU with src_b=0:
  - No issue, no stall, HI/LO unchanged, hilo_we=0.
- DIV_WAIT:
  - Hold div_start=1 and the operands.
  - Keep stallreq=1 until div_ready=1.
  - In the div_ready cycle: div_start=0, stallreq=0, hilo_we=1, hi_wdata=div_result[63:32], lo_wdata=div_result[31:0].
- After any commit:
  - If stall[EX_HOLD_BIT]=1, go DONE; else go IDLE.
  - MUL_LAT=0 and MTHI/MTLO commits also go DONE under hold.
- DONE:
  - md_op is ignored; no re-issue and no second commit.
  - hilo_we=0, stallreq=0.
  - Return to IDLE when stall[EX_HOLD_BIT]=0.
- HI/LO update: hi_o/lo_o←hi_wdata/lo_wdata at the edge where hilo_we=1. When hilo_we=0, hi_wdata/lo_wdata = hi_o/lo_o.
- Annul:
  - Takes effect in any state and has priority over commit, including a simultaneous div_ready or cnt=0.
  - No HI/LO write; div_annul=1 for one cycle if in DIV_WAIT; stallreq=0; next state IDLE.
- Reset has priority over annul and takes effect mid-operation.
- Arithmetic is done entirely by the units. The controller only selects and routes data and never alters widths or signs.

Test Plan:
- MTHI src_a=0x1234_5678, then MTLO src_a=0xDEAD_BEEF → hi_o=0x1234_5678, lo_o=0xDEAD_BEEF; hilo_we pulses 1 cycle each; stallreq never asserted.
- MULT 0xFFFF_FFFE×3, MUL_LAT=1 → stallreq=1 for 1 cycle; then hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFFA. With MULTU, hi_o=0x0000_0002.
- DIVU 100/7, div_ready after 33 cycles → div_start and stallreq high for 33 cycles, low in the ready cycle; then lo_o=14, hi_o=2. DIV −7/2 → lo_o=0xFFFF_FFFD, hi_o=0xFFFF_FFFF.
- DIV x/0 → no div_start, no stallreq, HI/LO unchanged.
- div_ready coincides with stall[2]=1 for 3 cycles, md_op held DIV → exactly one commit, state DONE for 3 cycles, no second div_start.
- annul asserted 5 cycles into DIV_WAIT → div_annul pulse, stallreq drops, HI/LO unchanged, next DIVU issues normally. rst asserted mid-MUL_WAIT → all outputs and HI/LO equal 0 next cycle.
